// File: rtl/seq_signed_divider_pkg.sv
// Shared definitions for the sequential signed/unsigned restoring divider:
// default operand width and FSM state encodings.
package seq_signed_divider_pkg;

    localparam int N_DEFAULT = 4;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/seq_signed_divider_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor magnitude when it fits and report the quotient bit.
module div_step #(
    parameter int N = 4
) (
    input  logic [N-1:0] r_in,
    input  logic         bit_in,
    input  logic [N-1:0] dvs,
    output logic [N-1:0] r_next,
    output logic         qbit
);

    logic [N:0]   shifted;
    logic [N-1:0] diff;

    // r_in is always below dvs, so the difference fits in N bits.
    always_comb begin
        shifted = {r_in, bit_in};
        diff    = shifted[N-1:0] - dvs;
        qbit    = (shifted >= {1'b0, dvs});
        r_next  = qbit ? diff : shifted[N-1:0];
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, unsigned or
// two's-complement, one quotient bit per cycle on a start/done handshake.
module seq_signed_divider
    import seq_signed_divider_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           sgn,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic [N-1:0]   q,
    output logic [N-1:0]   r,
    output logic           busy,
    output logic           done,
    output logic           dz,
    output logic           ovf
);

    localparam int CW = $clog2(2 * N);
    localparam logic [2*N-1:0] HALF = {{N{1'b0}}, 1'b1, {(N-1){1'b0}}};

    logic [2:0]     state_reg;
    logic [2*N-1:0] dvd_reg;
    logic [2*N-1:0] quot_reg;
    logic [N-1:0]   dvs_reg;
    logic [N-1:0]   rem_reg;
    logic           sgn_reg;
    logic           sign_q_reg;
    logic           sign_r_reg;
    logic [CW-1:0]  cnt_reg;
    logic [N-1:0]   q_reg;
    logic [N-1:0]   r_reg;
    logic           done_reg;
    logic           dz_reg;
    logic           ovf_reg;

    logic           dvd_neg;
    logic           dvs_neg;
    logic [2*N-1:0] dvd_mag;
    logic [N-1:0]   dvs_mag;
    logic [N-1:0]   step_r;
    logic           step_q;
    logic [N-1:0]   q_fix;
    logic [N-1:0]   r_fix;
    logic           ovf_calc;

    div_step #(.N(N)) u_step (
        .r_in   (rem_reg),
        .bit_in (dvd_reg[2*N-1]),
        .dvs    (dvs_reg),
        .r_next (step_r),
        .qbit   (step_q)
    );

    // The most-negative dividend maps to 2^(2N-1), which still fits unsigned.
    always_comb begin
        dvd_neg = sgn_reg & dvd_reg[2*N-1];
        dvs_neg = sgn_reg & dvs_reg[N-1];
        dvd_mag = dvd_neg ? -dvd_reg : dvd_reg;
        dvs_mag = dvs_neg ? -dvs_reg : dvs_reg;
        q_fix   = sign_q_reg ? -quot_reg[N-1:0] : quot_reg[N-1:0];
        r_fix   = sign_r_reg ? -rem_reg : rem_reg;
        if (!sgn_reg)
            ovf_calc = |quot_reg[2*N-1:N];
        else if (sign_q_reg)
            ovf_calc = (quot_reg > HALF);
        else
            ovf_calc = (quot_reg >= HALF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            dvd_reg    <= '0;
            quot_reg   <= '0;
            dvs_reg    <= '0;
            rem_reg    <= '0;
            sgn_reg    <= 1'b0;
            sign_q_reg <= 1'b0;
            sign_r_reg <= 1'b0;
            cnt_reg    <= '0;
            q_reg      <= '0;
            r_reg      <= '0;
            done_reg   <= 1'b0;
            dz_reg     <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // done_reg marks the done cycle, during which we are still busy.
                    if (start && !done_reg) begin
                        dvd_reg   <= dividend;
                        dvs_reg   <= divisor;
                        sgn_reg   <= sgn;
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (dvs_reg == '0) begin
                        q_reg     <= '1;
                        r_reg     <= dvd_reg[N-1:0];
                        dz_reg    <= 1'b1;
                        ovf_reg   <= 1'b0;
                        state_reg <= ST_DONE;
                    end else begin
                        dvd_reg    <= dvd_mag;
                        dvs_reg    <= dvs_mag;
                        sign_q_reg <= dvd_neg ^ dvs_neg;
                        sign_r_reg <= dvd_neg;
                        quot_reg   <= '0;
                        rem_reg    <= '0;
                        cnt_reg    <= '0;
                        state_reg  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    rem_reg  <= step_r;
                    quot_reg <= {quot_reg[2*N-2:0], step_q};
                    dvd_reg  <= {dvd_reg[2*N-2:0], 1'b0};
                    if (cnt_reg == CW'(2 * N - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_FIX;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                ST_FIX: begin
                    q_reg     <= q_fix;
                    r_reg     <= r_fix;
                    dz_reg    <= 1'b0;
                    ovf_reg   <= ovf_calc;
                    state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    done_reg  <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign q    = q_reg;
    assign r    = r_reg;
    assign done = done_reg;
    assign dz   = dz_reg;
    assign ovf  = ovf_reg;
    assign busy = (state_reg != ST_IDLE) || done_reg;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider (N=4): directed corner cases plus
// randomized operations against an integer-arithmetic reference model.
module tb_seq_signed_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sgn;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [3:0] q;
    logic [3:0] r;
    logic       busy;
    logic       done;
    logic       dz;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    seq_signed_divider #(.N(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sgn      (sgn),
        .dividend (dividend),
        .divisor  (divisor),
        .q        (q),
        .r        (r),
        .busy     (busy),
        .done     (done),
        .dz       (dz),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division (truncating, remainder takes dividend sign).
    function automatic void model(input logic s, input logic [7:0] a, input logic [3:0] b,
                                  output logic [9:0] exp_res);
        int x, y, qi, ri;
        logic eo;
        if (b == 4'd0) begin
            exp_res = {4'hF, a[3:0], 1'b1, 1'b0};
        end else begin
            x  = s ? int'($signed(a)) : int'(a);
            y  = s ? int'($signed(b)) : int'(b);
            qi = x / y;
            ri = x % y;
            eo = s ? (qi < -8 || qi > 7) : (qi > 15);
            exp_res = {qi[3:0], ri[3:0], 1'b0, eo};
        end
    endfunction

    // Issues one operation from a negedge; returns edges-to-done and {q,r,dz,ovf}.
    // Leaves the bench at the negedge of the cycle after done.
    task automatic run_op(input logic s, input logic [7:0] a, input logic [3:0] b,
                          output int lat, output logic [9:0] res);
        sgn = s; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        sgn = 1'($urandom); dividend = 8'($urandom); divisor = 4'($urandom);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res = {q, r, dz, ovf};
        $display("op sgn=%0d dvd=%h dvs=%h -> q=%h r=%h dz=%0d ovf=%0d lat=%0d",
                 s, a, b, q, r, dz, ovf, lat);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; sgn = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({q, r, busy, done, dz, ovf} !== 12'h000) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=000", {q, r, busy, done, dz, ovf});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unsigned;
        int lat; logic [9:0] res, exp_res;
        run_op(1'b0, 8'd100, 4'd7, lat, res);
        model(1'b0, 8'd100, 4'd7, exp_res);
        total++;
        if (res !== exp_res || res !== {4'd14, 4'd2, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL unsigned_100_7 got=%h want=%h", res, exp_res);
        end
        total++;
        if (lat !== 11) begin
            bad++;
            $display("FAIL unsigned_latency got=%0d want=11", lat);
        end
    endtask

    task automatic test_signed;
        int lat; logic [9:0] res;
        run_op(1'b1, 8'hF4, 4'd5, lat, res);
        total++;
        if (res !== {4'hE, 4'hE, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL signed_m12_5 got=%h want=%h", res, {4'hE, 4'hE, 2'b00});
        end
        run_op(1'b1, 8'd12, 4'hB, lat, res);
        total++;
        if (res !== {4'hE, 4'h2, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL signed_12_m5 got=%h want=%h", res, {4'hE, 4'h2, 2'b00});
        end
    endtask

    task automatic test_overflow;
        int lat; logic [9:0] res, exp_res;
        run_op(1'b0, 8'd200, 4'd3, lat, res);
        model(1'b0, 8'd200, 4'd3, exp_res);
        total++;
        if (res !== exp_res || res[0] !== 1'b1) begin
            bad++;
            $display("FAIL ovf_unsigned got=%h want=%h", res, exp_res);
        end
        run_op(1'b1, 8'h80, 4'hF, lat, res);
        model(1'b1, 8'h80, 4'hF, exp_res);
        total++;
        if (res !== exp_res || res[0] !== 1'b1) begin
            bad++;
            $display("FAIL ovf_most_negative got=%h want=%h", res, exp_res);
        end
        run_op(1'b1, 8'hF8, 4'h1, lat, res);
        total++;
        if (res !== {4'h8, 4'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL ovf_edge_m8 got=%h want=%h", res, {4'h8, 4'h0, 2'b00});
        end
    endtask

    task automatic test_div_zero;
        int lat; logic [9:0] res;
        run_op(1'b0, 8'd37, 4'd0, lat, res);
        total++;
        if (res !== {4'hF, 4'h5, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL div_zero got=%h want=%h", res, {4'hF, 4'h5, 2'b10});
        end
        total++;
        if (lat !== 2) begin
            bad++;
            $display("FAIL div_zero_latency got=%0d want=2", lat);
        end
    endtask

    task automatic test_handshake;
        int n, lat; logic [9:0] res, exp_res;
        sgn = 1'b0; dividend = 8'd100; divisor = 4'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_during_op got=%b want=1", busy);
        end
        sgn = 1'b1; dividend = 8'd45; divisor = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        model(1'b0, 8'd100, 4'd7, exp_res);
        total++;
        if ({q, r, dz, ovf} !== exp_res || n >= 40) begin
            bad++;
            $display("FAIL start_while_busy got=%h want=%h", {q, r, dz, ovf}, exp_res);
        end
        $display("op handshake first result q=%h r=%h", q, r);
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_after_done got=%b want=0", busy);
        end
        run_op(1'b1, 8'hF4, 4'd5, lat, res);
        model(1'b1, 8'hF4, 4'd5, exp_res);
        total++;
        if (res !== exp_res || lat !== 11) begin
            bad++;
            $display("FAIL back_to_back got=%h lat=%0d want=%h lat=11", res, lat, exp_res);
        end
    endtask

    task automatic test_reset_mid;
        int lat; logic [9:0] res, exp_res;
        logic seen_done;
        sgn = 1'b0; dividend = 8'd150; divisor = 4'd4; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({q, r, busy, done, dz, ovf} !== 12'h000) begin
            bad++;
            $display("FAIL reset_mid_outputs got=%h want=000", {q, r, busy, done, dz, ovf});
        end
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        total++;
        if (seen_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_no_done got=%b want=0", seen_done);
        end
        run_op(1'b0, 8'd100, 4'd7, lat, res);
        model(1'b0, 8'd100, 4'd7, exp_res);
        total++;
        if (res !== exp_res || lat !== 11) begin
            bad++;
            $display("FAIL after_reset_op got=%h lat=%0d want=%h lat=11", res, lat, exp_res);
        end
    endtask

    task automatic test_random;
        int lat; logic [9:0] res, exp_res;
        logic s; logic [7:0] a; logic [3:0] b;
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom);
            a = 8'($urandom);
            b = 4'($urandom_range(0, 15));
            run_op(s, a, b, lat, res);
            model(s, a, b, exp_res);
            total++;
            if (res !== exp_res) begin
                bad++;
                $display("FAIL random_%0d sgn=%0d dvd=%h dvs=%h got=%h want=%h",
                         i, s, a, b, res, exp_res);
            end
            total++;
            if (lat !== ((b == 4'd0) ? 2 : 11)) begin
                bad++;
                $display("FAIL random_latency_%0d got=%0d want=%0d", i, lat, (b == 4'd0) ? 2 : 11);
            end
        end
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_overflow;
        test_div_zero;
        test_handshake;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
